// File: rtl/adma_as_atx_split.sv
// adma_as_atx_split
// Splits one DMA transfer descriptor (start address, length in beats) into
// AXI burst commands. Each burst is limited by MAX_BURST and by the 4 KB
// boundary. After the last burst is accepted, the block waits for tx_done
// from the status stage before it accepts another descriptor.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   tx_vld/tx_rdy       descriptor handshake (tx_rdy high only in IDLE)
//   tx_addr, tx_len     descriptor start byte address, length in beats
//   atx_vld/atx_rdy     burst command handshake
//   atx_addr, atx_len   burst start address (beat aligned), AxLEN (beats-1)
//   atx_start           burst command accepted this cycle
//   atx_start_last      accepted burst is the final one of the descriptor
//   tx_done             status stage reports the whole transfer complete
//   tx_zero             one-cycle pulse: a zero-length descriptor was consumed
//   busy                not IDLE
module adma_as_atx_split #(
    parameter int ADDR_W       = 32,
    parameter int DMA_LENGTH_W = 16,
    parameter int DATA_W       = 32,
    parameter int MAX_BURST    = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tx_vld,
    output logic                    tx_rdy,
    input  logic [ADDR_W-1:0]       tx_addr,
    input  logic [DMA_LENGTH_W-1:0] tx_len,
    output logic                    atx_vld,
    input  logic                    atx_rdy,
    output logic [ADDR_W-1:0]       atx_addr,
    output logic [7:0]              atx_len,
    output logic                    atx_start,
    output logic                    atx_start_last,
    input  logic                    tx_done,
    output logic                    tx_zero,
    output logic                    busy
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFFS  = $clog2(BYTES);
    // Burst arithmetic width: wide enough for the 4 KB beat count and for rem.
    localparam int CW    = (DMA_LENGTH_W > 13) ? DMA_LENGTH_W : 13;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_W-1:0]       cur_addr;
    logic [DMA_LENGTH_W-1:0] rem;
    logic [12:0]             b4k;
    logic [CW-1:0]           rem_w;
    logic [CW-1:0]           burst;
    logic [7:0]              len_live;
    logic                    last;
    logic [ADDR_W-1:0]       hold_addr;
    logic [7:0]              hold_len;
    logic                    tx_zero_q;

    // Burst size from the current registers: min(rem, MAX_BURST, beats to 4 KB).
    always_comb begin
        b4k   = (13'd4096 - {1'b0, cur_addr[11:0]}) >> OFFS;
        rem_w = CW'(rem);
        burst = rem_w;
        if (burst > CW'(MAX_BURST)) burst = CW'(MAX_BURST);
        if (burst > CW'(b4k))       burst = CW'(b4k);
        last     = (burst == rem_w);
        len_live = 8'(burst - CW'(1));
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (tx_vld && (tx_len != '0)) state_d = ISSUE;
            ISSUE:     if (atx_rdy && last)          state_d = WAIT_DONE;
            WAIT_DONE: if (tx_done)                  state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Outputs; outside ISSUE the command fields show the last accepted burst.
    always_comb begin
        tx_rdy         = (state_q == IDLE);
        atx_vld        = (state_q == ISSUE);
        busy           = (state_q != IDLE);
        atx_start      = atx_vld & atx_rdy;
        atx_start_last = atx_start & last;
        atx_addr       = atx_vld ? cur_addr : hold_addr;
        atx_len        = atx_vld ? len_live : hold_len;
        tx_zero        = tx_zero_q;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr  <= '0;
            rem       <= '0;
            hold_addr <= '0;
            hold_len  <= '0;
            tx_zero_q <= 1'b0;
        end else begin
            tx_zero_q <= (state_q == IDLE) && tx_vld && (tx_len == '0);
            if ((state_q == IDLE) && tx_vld) begin
                cur_addr <= tx_addr & ALIGN_MASK;
                rem      <= tx_len;
            end
            if (atx_start) begin
                cur_addr  <= cur_addr + (ADDR_W'(burst) << OFFS);
                rem       <= rem - DMA_LENGTH_W'(burst);
                hold_addr <= cur_addr;
                hold_len  <= len_live;
            end
        end
    end

endmodule

// File: tb/tb_adma_as_atx_split.sv
module tb_adma_as_atx_split;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tx_vld;
    logic        tx_rdy;
    logic [31:0] tx_addr;
    logic [15:0] tx_len;
    logic        atx_vld;
    logic        atx_rdy;
    logic [31:0] atx_addr;
    logic [7:0]  atx_len;
    logic        atx_start;
    logic        atx_start_last;
    logic        tx_done;
    logic        tx_zero;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int n_starts = 0;

    adma_as_atx_split #(
        .ADDR_W      (32),
        .DMA_LENGTH_W(16),
        .DATA_W      (32),
        .MAX_BURST   (256)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tx_vld        (tx_vld),
        .tx_rdy        (tx_rdy),
        .tx_addr       (tx_addr),
        .tx_len        (tx_len),
        .atx_vld       (atx_vld),
        .atx_rdy       (atx_rdy),
        .atx_addr      (atx_addr),
        .atx_len       (atx_len),
        .atx_start     (atx_start),
        .atx_start_last(atx_start_last),
        .tx_done       (tx_done),
        .tx_zero       (tx_zero),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && atx_start) n_starts++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".tx_rdy"},   32'(tx_rdy), 32'd1);
        check({tag, ".atx_vld"},  32'(atx_vld), 32'd0);
        check({tag, ".start"},    32'(atx_start), 32'd0);
        check({tag, ".last"},     32'(atx_start_last), 32'd0);
        check({tag, ".tx_zero"},  32'(tx_zero), 32'd0);
        check({tag, ".busy"},     32'(busy), 32'd0);
        check({tag, ".atx_addr"}, atx_addr, 32'h0);
        check({tag, ".atx_len"},  32'(atx_len), 32'd0);
    endtask

    // Present a descriptor for one cycle (block must be in IDLE).
    task automatic issue_desc(input string tag, input logic [31:0] a, input logic [15:0] l);
        tx_vld  = 1'b1;
        tx_addr = a;
        tx_len  = l;
        settle();
        check({tag, ".tx_rdy"}, 32'(tx_rdy), 32'd1);
        tick();
        tx_vld = 1'b0;
    endtask

    // Expect one burst command, optionally stalled first with atx_rdy low.
    task automatic expect_burst(input string tag, input logic [31:0] a, input logic [7:0] l,
                                input logic is_last, input int stall);
        for (int i = 0; i < stall; i++) begin
            atx_rdy = 1'b0;
            settle();
            check({tag, ".stall_vld"},   32'(atx_vld), 32'd1);
            check({tag, ".stall_addr"},  atx_addr, a);
            check({tag, ".stall_len"},   32'(atx_len), 32'(l));
            check({tag, ".stall_start"}, 32'(atx_start), 32'd0);
            tick();
        end
        atx_rdy = 1'b1;
        settle();
        check({tag, ".vld"},   32'(atx_vld), 32'd1);
        check({tag, ".busy"},  32'(busy), 32'd1);
        check({tag, ".rdy"},   32'(tx_rdy), 32'd0);
        check({tag, ".addr"},  atx_addr, a);
        check({tag, ".len"},   32'(atx_len), 32'(l));
        check({tag, ".start"}, 32'(atx_start), 32'd1);
        check({tag, ".last"},  32'(atx_start_last), 32'(is_last));
        tick();
    endtask

    // In WAIT_DONE: pulse tx_done and expect IDLE on the next cycle.
    task automatic finish_done(input string tag);
        settle();
        check({tag, ".wait_vld"},  32'(atx_vld), 32'd0);
        check({tag, ".wait_rdy"},  32'(tx_rdy), 32'd0);
        check({tag, ".wait_busy"}, 32'(busy), 32'd1);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        settle();
        check({tag, ".idle_rdy"},  32'(tx_rdy), 32'd1);
        check({tag, ".idle_busy"}, 32'(busy), 32'd0);
    endtask

    int starts_before;

    initial begin
        rst_n   = 1'b0;
        tx_vld  = 1'b0;
        tx_addr = '0;
        tx_len  = '0;
        atx_rdy = 1'b1;
        tx_done = 1'b0;
        #2;
        check_reset_outputs("reset");
        tick();
        rst_n = 1'b1;
        tick();

        // 1: single burst
        issue_desc("s1", 32'h0000, 16'd16);
        expect_burst("s1.b0", 32'h0000, 8'd15, 1'b1, 0);
        finish_done("s1");
        check("s1.hold_addr", atx_addr, 32'h0000);
        check("s1.hold_len",  32'(atx_len), 32'd15);
        tick();

        // 2: 4 KB boundary split
        issue_desc("s2", 32'h0FF0, 16'd16);
        expect_burst("s2.b0", 32'h0FF0, 8'd3,  1'b0, 0);
        expect_burst("s2.b1", 32'h1000, 8'd11, 1'b1, 0);
        finish_done("s2");
        tick();

        // 3: max-burst split, back to back
        issue_desc("s3", 32'h0000, 16'd600);
        expect_burst("s3.b0", 32'h000, 8'd255, 1'b0, 0);
        expect_burst("s3.b1", 32'h400, 8'd255, 1'b0, 0);
        expect_burst("s3.b2", 32'h800, 8'd87,  1'b1, 0);
        finish_done("s3");
        tick();

        // 4: backpressure; a tx_done during ISSUE must be ignored
        starts_before = n_starts;
        issue_desc("s4", 32'h0000, 16'd600);
        atx_rdy = 1'b0;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        settle();
        check("s4.done_ignored_vld", 32'(atx_vld), 32'd1);
        expect_burst("s4.b0", 32'h000, 8'd255, 1'b0, 4);
        expect_burst("s4.b1", 32'h400, 8'd255, 1'b0, 5);
        expect_burst("s4.b2", 32'h800, 8'd87,  1'b1, 5);
        check("s4.start_count", 32'(n_starts - starts_before), 32'd3);
        finish_done("s4");
        tick();

        // 5: zero length, spurious done, unaligned address
        starts_before = n_starts;
        issue_desc("s5", 32'h0000, 16'd0);
        settle();
        check("s5.tx_zero",  32'(tx_zero), 32'd1);
        check("s5.atx_vld",  32'(atx_vld), 32'd0);
        check("s5.tx_rdy",   32'(tx_rdy), 32'd1);
        check("s5.busy",     32'(busy), 32'd0);
        tick();
        check("s5.tx_zero_end", 32'(tx_zero), 32'd0);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        settle();
        check("s5.spur_rdy",  32'(tx_rdy), 32'd1);
        check("s5.spur_vld",  32'(atx_vld), 32'd0);
        check("s5.spur_busy", 32'(busy), 32'd0);
        check("s5.no_starts", 32'(n_starts - starts_before), 32'd0);
        issue_desc("s5u", 32'h0000_0103, 16'd1);
        expect_burst("s5u.b0", 32'h0000_0100, 8'd0, 1'b1, 0);
        finish_done("s5u");
        tick();

        // 6: reset mid-operation
        issue_desc("s6", 32'h0000, 16'd600);
        expect_burst("s6.b0", 32'h000, 8'd255, 1'b0, 0);
        atx_rdy = 1'b1;
        settle();
        check("s6.pre_vld", 32'(atx_vld), 32'd1);
        rst_n = 1'b0;
        settle();
        check_reset_outputs("s6.rst");
        tick();
        rst_n = 1'b1;
        tick();
        issue_desc("s6n", 32'h2000, 16'd4);
        expect_burst("s6n.b0", 32'h2000, 8'd3, 1'b1, 0);
        finish_done("s6n");
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
